// File: rtl/pdp8i_iop_pkg.sv
// Shared types and helpers for the PDP-8/I IOT pulse sequencer.
// Holds the sequencer state encoding, the slot index constants that
// address IR[9:11], and helpers for sizing the slot counter and for
// picking the next selected slot.
package pdp8i_iop_pkg;

  // Sequencer states. Each slot is followed by its dead-time gap.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    G1   = 3'd2,
    S2   = 3'd3,
    G2   = 3'd4,
    S4   = 3'd5,
    G4   = 3'd6
  } iop_state_t;

  // Bit positions of the latched IR bits that enable each pulse.
  localparam int SLOT_IOP1 = 0;  // IR11
  localparam int SLOT_IOP2 = 1;  // IR10
  localparam int SLOT_IOP4 = 2;  // IR9

  // Width of the slot counter: enough bits to hold max(pulse_w, gap_w)-1.
  // A width of 1 is the floor so a 1-cycle slot still has a real register.
  function automatic int cnt_width(input int pulse_w, input int gap_w);
    int m;
    int w;
    m = (pulse_w > gap_w) ? pulse_w : gap_w;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  // First slot at or after slot index 'from' whose enable bit is set.
  // Returns IDLE when no later slot is selected.
  function automatic iop_state_t first_slot(input logic [2:0] lat,
                                            input int       from);
    if ((from <= SLOT_IOP1) && lat[SLOT_IOP1]) return S1;
    if ((from <= SLOT_IOP2) && lat[SLOT_IOP2]) return S2;
    if ((from <= SLOT_IOP4) && lat[SLOT_IOP4]) return S4;
    return IDLE;
  endfunction

endpackage

// File: rtl/iop_slot_timer.sv
// Loadable down-counter that times one IOP slot or gap.
// A load takes priority; otherwise the count decrements and holds at 0.
// o_zero flags the last cycle of the current slot or gap.
module iop_slot_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Count register: synchronous clear, load, or decrement toward zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; reset is synchronous, checked inside the edge.
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/iop_sequencer.sv
// PDP-8/I IOT pulse sequencer.
// On start (sampled in IDLE) latches IR[9:11] and steps through the fixed
// slot order S1,G1,S2,G2,S4,G4. Each slot lasts PULSE_W cycles and each gap
// GAP_W cycles. iop1/iop2/iop4 are one-hot enables for the negative output
// converter channels; busy requests IO pause; done pulses for one cycle in
// the first IDLE cycle after the sequence ends.
//
// Build option: define IOP_SKIP_EMPTY_EN to skip slots (and their gaps)
// whose latched IR bit is 0. With all bits clear the sequencer never leaves
// IDLE and done pulses in the cycle after start. Without the macro, timing
// is fixed and unselected slots still take their full time.
module iop_sequencer
  import pdp8i_iop_pkg::*;
#(
  parameter int PULSE_W = 25,
  parameter int GAP_W   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] ir_bits,
  output logic       iop1,
  output logic       iop2,
  output logic       iop4,
  output logic       busy,
  output logic       done
);

  localparam int             CW      = cnt_width(PULSE_W, GAP_W);
  localparam logic [CW-1:0]  PW_LOAD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0]  GW_LOAD = CW'(GAP_W - 1);

  iop_state_t    r_state;
  logic [2:0]    r_lat;
  logic          r_iop1;
  logic          r_iop2;
  logic          r_iop4;
  logic          r_busy;
  logic          r_done;

  iop_state_t    w_nxt_state;
  logic [2:0]    w_nxt_lat;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_finish;
  logic          w_zero;

  // Where the sequence goes after leaving IDLE, G1 and G2.
  iop_state_t    w_after_idle;
  iop_state_t    w_after_g1;
  iop_state_t    w_after_g2;

`ifdef IOP_SKIP_EMPTY_EN
  assign w_after_idle = first_slot(ir_bits, SLOT_IOP1);
  assign w_after_g1   = first_slot(r_lat, SLOT_IOP2);
  assign w_after_g2   = first_slot(r_lat, SLOT_IOP4);
`else
  assign w_after_idle = S1;
  assign w_after_g1   = S2;
  assign w_after_g2   = S4;
`endif

  iop_slot_timer #(
    .W (CW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  // Next-state decision plus counter load for the state being entered.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    w_nxt_state = r_state;
    w_nxt_lat   = r_lat;
    w_load      = 1'b0;
    w_load_val  = PW_LOAD;
    w_finish    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_nxt_lat   = ir_bits;
          w_nxt_state = w_after_idle;
          if (w_after_idle == IDLE) begin
            w_finish = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S1: begin
        if (w_zero) begin
          w_nxt_state = G1;
          w_load      = 1'b1;
          w_load_val  = GW_LOAD;
        end
      end
      G1: begin
        if (w_zero) begin
          w_nxt_state = w_after_g1;
          if (w_after_g1 == IDLE) begin
            w_finish = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S2: begin
        if (w_zero) begin
          w_nxt_state = G2;
          w_load      = 1'b1;
          w_load_val  = GW_LOAD;
        end
      end
      G2: begin
        if (w_zero) begin
          w_nxt_state = w_after_g2;
          if (w_after_g2 == IDLE) begin
            w_finish = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S4: begin
        if (w_zero) begin
          w_nxt_state = G4;
          w_load      = 1'b1;
          w_load_val  = GW_LOAD;
        end
      end
      G4: begin
        if (w_zero) begin
          w_nxt_state = IDLE;
          w_finish    = 1'b1;
        end
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  // State, latched IR bits and registered outputs. Outputs are computed
  // from the state being entered so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_lat   <= 3'b000;
      r_iop1  <= 1'b0;
      r_iop2  <= 1'b0;
      r_iop4  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_lat   <= w_nxt_lat;
      r_iop1  <= (w_nxt_state == S1) && w_nxt_lat[SLOT_IOP1];
      r_iop2  <= (w_nxt_state == S2) && w_nxt_lat[SLOT_IOP2];
      r_iop4  <= (w_nxt_state == S4) && w_nxt_lat[SLOT_IOP4];
      r_busy  <= (w_nxt_state != IDLE);
      r_done  <= w_finish;
    end
  end

  assign iop1 = r_iop1;
  assign iop2 = r_iop2;
  assign iop4 = r_iop4;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_iop_sequencer.sv
// Directed scoreboard bench for iop_sequencer with PULSE_W=4, GAP_W=2.
// Cycle c is the cycle following the c-th rising edge after the case
// begins; inputs scheduled for cycle c are sampled at the edge that ends it.
// Expected output vectors {iop1,iop2,iop4,busy,done} come from the latency
// formulas of the sequence and are queued before each case is played.
module tb_iop_sequencer;

  localparam int P = 4;
  localparam int G = 2;
  localparam int MAXC = 64;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] ir_bits;
  logic       iop1;
  logic       iop2;
  logic       iop4;
  logic       busy;
  logic       done;

  int n_vec;
  int n_fail;

  logic [4:0] sb[$];

  logic       st_sched[MAXC];
  logic       rs_sched[MAXC];
  logic [2:0] ir_sched[MAXC];

  iop_sequencer #(
    .PULSE_W (P),
    .GAP_W   (G)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ir_bits (ir_bits),
    .iop1    (iop1),
    .iop2    (iop2),
    .iop4    (iop4),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-timing expectation for one sequence started in cycle t0.
  function automatic logic [4:0] model(input int c, input int t0,
                                       input logic [2:0] lat);
    logic [4:0] v;
    v = '0;
    for (int k = 0; k < 3; k++) begin
      if (lat[k] && (c >= t0 + 1 + k * (P + G)) &&
          (c <= t0 + (k + 1) * P + k * G))
        v[4 - k] = 1'b1;
    end
    v[1] = (c >= t0 + 1) && (c <= t0 + 3 * (P + G));
    v[0] = (c == t0 + 1 + 3 * (P + G));
    return v;
  endfunction

  task automatic clear_sched();
    for (int c = 0; c < MAXC; c++) begin
      st_sched[c] = 1'b0;
      rs_sched[c] = 1'b0;
      ir_sched[c] = 3'b000;
    end
    sb.delete();
  endtask

  task automatic play(input string tag, input int ncyc);
    logic [4:0] obs;
    logic [4:0] exp_v;
    for (int c = 0; c < ncyc; c++) begin
      start   = st_sched[c];
      rst     = rs_sched[c];
      ir_bits = ir_sched[c];
      @(posedge clk);
      #1;
      start = 1'b0;
      rst   = 1'b0;
      obs   = {iop1, iop2, iop4, busy, done};
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL %s cyc %0d: scoreboard empty, observed %b", tag, c + 1, obs);
      end else begin
        exp_v = sb.pop_front();
        assert (obs === exp_v) else begin
          n_fail++;
          $error("FAIL %s cyc %0d: observed %b expected %b (iop1 iop2 iop4 busy done)",
                 tag, c + 1, obs, exp_v);
        end
      end
    end
  endtask

  initial begin
    n_vec   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    ir_bits = 3'b000;

    // Reset state: all outputs low, start ignored while in reset.
    clear_sched();
    rs_sched[0] = 1'b1;
    rs_sched[1] = 1'b1;
    st_sched[1] = 1'b1;
    ir_sched[1] = 3'b111;
    sb.push_back(5'b00000);
    sb.push_back(5'b00000);
    play("reset", 2);

    // All three pulses.
    clear_sched();
    st_sched[0] = 1'b1;
    for (int c = 0; c < MAXC; c++) ir_sched[c] = 3'b111;
    for (int c = 1; c <= 21; c++) sb.push_back(model(c, 0, 3'b111));
    play("ir111", 21);

    // Extra starts while busy are dropped; start with done runs again.
    clear_sched();
    st_sched[0]  = 1'b1;
    st_sched[5]  = 1'b1;
    st_sched[12] = 1'b1;
    st_sched[19] = 1'b1;
    for (int c = 0; c < MAXC; c++) ir_sched[c] = 3'b111;
    for (int c = 1; c <= 40; c++)
      sb.push_back(model(c, 0, 3'b111) | model(c, 19, 3'b111));
    play("b2b", 40);

    // Reset in the middle of iop2, then a clean restart.
    clear_sched();
    st_sched[0]  = 1'b1;
    rs_sched[8]  = 1'b1;
    st_sched[10] = 1'b1;
    for (int c = 0; c < MAXC; c++) ir_sched[c] = 3'b111;
    for (int c = 1; c <= 32; c++)
      sb.push_back((c <= 8) ? model(c, 0, 3'b111) : model(c, 10, 3'b111));
    play("midrst", 32);

`ifndef IOP_SKIP_EMPTY_EN
    // Only iop2 selected; unselected slots keep full timing.
    clear_sched();
    st_sched[0] = 1'b1;
    for (int c = 0; c < MAXC; c++) ir_sched[c] = 3'b010;
    for (int c = 1; c <= 21; c++) sb.push_back(model(c, 0, 3'b010));
    play("ir010", 21);

    // ir_bits change mid-sequence must not alter the latched selection.
    clear_sched();
    st_sched[0] = 1'b1;
    for (int c = 0; c < MAXC; c++) ir_sched[c] = (c < 3) ? 3'b001 : 3'b110;
    for (int c = 1; c <= 21; c++) sb.push_back(model(c, 0, 3'b001));
    play("irchg", 21);
`else
    // Skip mode, only iop4: iop4 1-4, busy 1-6, done at 7.
    clear_sched();
    st_sched[0] = 1'b1;
    for (int c = 0; c < MAXC; c++) ir_sched[c] = 3'b100;
    for (int c = 1; c <= 9; c++)
      sb.push_back({2'b00, (c >= 1 && c <= 4), (c >= 1 && c <= 6), (c == 7)});
    play("skip100", 9);

    // Skip mode, nothing selected: busy never rises, done at 1.
    clear_sched();
    st_sched[0] = 1'b1;
    for (int c = 1; c <= 3; c++) sb.push_back({4'b0000, (c == 1)});
    play("skip000", 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/iop_sequencer.md
Name: iop_sequencer

Overview:
- Generates the PDP-8/I IOT pulses IOP1, IOP2 and IOP4 in fixed order with programmable width and spacing.
- Its three one-hot pulse outputs drive the enable inputs of the negative output converter channels that put IOP levels onto the peripheral bus.
- Started by the major-state logic at IOT execute. Returns `done` so the processor can leave IO pause.

Parameters:
- PULSE_W, 25, width of each IOP slot in clk cycles (>=1).
- GAP_W, 15, dead time after each slot in clk cycles (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to run a sequence; sampled only in IDLE.
- ir_bits  input  3  IR[9:11] of the current IOT:
  - [0] = IR11, enables IOP1.
  - [1] = IR10, enables IOP2.
  - [2] = IR9, enables IOP4.
- iop1  output  1  IOP1 enable to converter channel.
- iop2  output  1  IOP2 enable to converter channel.
- iop4  output  1  IOP4 enable to converter channel.
- busy  output  1  sequence in progress (IO pause request).
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, `clk`. `rst` is synchronous, active-high; clock and reset are already decided.
- Reset values: all outputs are 0, state is IDLE, counter is 0, latched bits are 0.
- `rst` mid-sequence aborts on the next edge; the pulse output drops with no truncation guard.
- States: IDLE, S1, G1, S2, G2, S4, G4.
  - S1, S2 and S4 each last PULSE_W cycles.
  - G1, G2 and G4 each last GAP_W cycles.
  - Order is fixed: S1, G1, S2, G2, S4, G4.
- Start: in IDLE with start=1, `ir_bits` is latched. The next cycle enters S1 with the counter loaded to PULSE_W-1.
- Counting: the counter decrements each cycle. When it reaches 0, the next state loads the counter to its own width-1.
- Registered outputs:
  - iop1 = (state==S1) & lat[0].
  - iop2 = (state==S2) & lat[1].
  - iop4 = (state==S4) & lat[2].
  - At most one is high at any time.
- Unselected slots still consume full PULSE_W time (fixed timing), but the corresponding output stays low.
- busy = (state != IDLE).
- done: high for exactly one cycle, the first IDLE cycle after G4 completes.
  - start in that same cycle is accepted; back-to-back sequences are allowed.
- Latency: start at edge t0. Slot k (k=0,1,2) is high in cycles t0+1+k*(PULSE_W+GAP_W) through t0+(k+1)*PULSE_W+k*GAP_W. done is at cycle t0+1+3*(PULSE_W+GAP_W).
- Ignored inputs:
  - start while busy is ignored; no queueing.
  - ir_bits changes during a sequence have no effect.

Optional Feature:
- Macro: IOP_SKIP_EMPTY_EN.
- Defined:
  - Slots whose latched bit is 0 are skipped entirely, together with their following gap.
  - The next selected slot follows immediately.
  - If lat==000, no state other than IDLE is entered, busy stays 0, and done pulses in cycle t0+1.
- Undefined: fixed timing as above.

Decomposition:
- Package pdp8i_iop_pkg:
  - State enum iop_state_t.
  - Slot index constants SLOT_IOP1/2/4.
  - Helper function for counter width, clog2 of max(PULSE_W,GAP_W).
- Sub-module iop_slot_timer:
  - Loadable down-counter with load value and `zero` flag.
  - Instantiated once.

Test Plan (bench PULSE_W=4, GAP_W=2, start at t0):
- ir=111, macro off -> iop1 cycles 1-4, iop2 7-10, iop4 13-16; busy 1-18; done only at 19.
- ir=010, macro off -> only iop2 at cycles 7-10; iop1/iop4 never high; done at 19.
- start at t0 plus start pulses at cycles 5 and 12 -> extra starts ignored, single sequence; start at cycle 19 (with done) -> second sequence, iop1 cycles 20-23.
- rst asserted at cycle 8 (mid iop2) -> cycle 9 all outputs 0, IDLE; a start at cycle 10 runs a clean sequence with iop1 cycles 11-14.
- ir_bits changed from 001 to 110 at cycle 3 -> only iop1 cycles 1-4; no iop2/iop4.
- Macro on: ir=100 -> iop4 cycles 1-4, busy 1-6, done at 7; ir=000 -> busy never high, done at 1.
